sc_matrix_scan_driver: RTL

- Downstream consumer of the row-register bank: takes the parallel outputs of the ROWS matrix row registers and time-multiplexes them onto a physical 8x8 LED matrix.
- Per frame: latches a tear-free snapshot, then activates one row at a time with its column pattern.
- Inserts blanking dead-time between rows to suppress ghosting.
- Sits between the row-register bank and the board's row/column pins.

---
 rtl/sc_matrix_pkg.sv | 18 +
 rtl/sc_matrix_prescaler.sv | 45 ++++
 rtl/sc_matrix_scan_driver.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sc_matrix_pkg.sv
// Shared types and defaults for the LED matrix scan driver.
// Holds the default geometry, the scan state encoding and an index-width helper.
package sc_matrix_pkg;

   localparam int DEF_ROWS      = 8;
   localparam int DEF_DATAWIDTH = 8;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   // Width of an index into n items; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sc_matrix_prescaler.sv
// Row-slot prescaler: counts 0..SCAN_DIV-1 while enabled, cleared on demand.
// Ports: clock/reset, clr_InHigh, en_InHigh, p_next_Out (count after this edge), tick_OutHigh (last cycle of slot).
import sc_matrix_pkg::*;

module sc_matrix_prescaler #(
   parameter int SCAN_DIV = 50000
) (
   input  logic                          SC_Reg_MATRIX_CLOCK_50,
   input  logic                          SC_Reg_MATRIX_RESET_InHigh,
   input  logic                          clr_InHigh,
   input  logic                          en_InHigh,
   output logic [idx_w(SCAN_DIV)-1:0]    p_next_Out,
   output logic                          tick_OutHigh
);

   localparam int PW = idx_w(SCAN_DIV);
   localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);

   logic [PW-1:0] p_q;
   logic [PW-1:0] p_d;
   logic          tick;

   always_comb begin
      tick = en_InHigh && !clr_InHigh && (p_q == P_LAST);
      p_d  = p_q;
      if (clr_InHigh) begin
         p_d = '0;
      end else if (en_InHigh) begin
         p_d = tick ? '0 : p_q + PW'(1);
      end
   end

   always_ff @(posedge SC_Reg_MATRIX_CLOCK_50 or posedge SC_Reg_MATRIX_RESET_InHigh) begin
      if (SC_Reg_MATRIX_RESET_InHigh) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   // The next count lets the parent register its outputs in step with the counter.
   assign p_next_Out   = p_d;
   assign tick_OutHigh = tick;

endmodule

// File: rtl/sc_matrix_scan_driver.sv
// Time-multiplexes a snapshot of the row-register bank onto an 8x8 LED matrix with per-row blanking.
// Ports: clock/reset, scan_enable_InHigh, frame_InBUS in; row_OutBUS, col_OutBUS, row_index_Out, frame_done_OutHigh out.
import sc_matrix_pkg::*;

module sc_matrix_scan_driver #(
   parameter int DATAWIDTH      = DEF_DATAWIDTH,
   parameter int ROWS           = DEF_ROWS,
   parameter int SCAN_DIV       = 50000,
   parameter int BLANK_CYCLES   = 4,
   parameter int ROW_ACTIVE_LOW = 1,
   parameter int COL_ACTIVE_LOW = 0
) (
   input  logic                      SC_Reg_MATRIX_CLOCK_50,
   input  logic                      SC_Reg_MATRIX_RESET_InHigh,
   input  logic                      scan_enable_InHigh,
   input  logic [ROWS*DATAWIDTH-1:0] frame_InBUS,
   output logic [ROWS-1:0]           row_OutBUS,
   output logic [DATAWIDTH-1:0]      col_OutBUS,
   output logic [idx_w(ROWS)-1:0]    row_index_Out,
   output logic                      frame_done_OutHigh
);

   localparam int RW = idx_w(ROWS);
   localparam int PW = idx_w(SCAN_DIV);
   localparam logic [RW-1:0]        ROW_LAST = RW'(ROWS - 1);
   localparam logic [ROWS-1:0]      ROW_OFF  = (ROW_ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [DATAWIDTH-1:0] COL_OFF  = (COL_ACTIVE_LOW != 0) ? '1 : '0;

   state_t                    state_q, state_d;
   logic [RW-1:0]             row_q, row_d;
   logic [ROWS*DATAWIDTH-1:0] snap_q, snap_d;
   logic                      fd_q, fd_d;
   logic [ROWS-1:0]           rowo_q, rowo_d;
   logic [DATAWIDTH-1:0]      colo_q, colo_d;

   logic          clr;
   logic          en;
   logic          tick;
   logic [PW-1:0] p_next;
   logic          drive;
   logic [ROWS-1:0]      sel;
   logic [DATAWIDTH-1:0] col;

   sc_matrix_prescaler #(
      .SCAN_DIV (SCAN_DIV)
   ) u_presc (
      .SC_Reg_MATRIX_CLOCK_50     (SC_Reg_MATRIX_CLOCK_50),
      .SC_Reg_MATRIX_RESET_InHigh (SC_Reg_MATRIX_RESET_InHigh),
      .clr_InHigh                 (clr),
      .en_InHigh                  (en),
      .p_next_Out                 (p_next),
      .tick_OutHigh               (tick)
   );

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      snap_d  = snap_q;
      fd_d    = 1'b0;
      clr     = 1'b1;
      en      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            row_d = '0;
            if (scan_enable_InHigh) begin
               state_d = S_ACTIVE;
               snap_d  = frame_InBUS;
            end
         end
         S_ACTIVE: begin
            if (!scan_enable_InHigh) begin
               state_d = S_IDLE;
               row_d   = '0;
            end else begin
               clr = 1'b0;
               en  = 1'b1;
               if (tick) begin
                  row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                  // Frame wrap: take a fresh tear-free copy for the next frame.
                  if (row_q == ROW_LAST) begin
                     snap_d = frame_InBUS;
                     fd_d   = 1'b1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output encoding is computed from the next state so the pins change
   // on the same edge as the counters they describe.
   always_comb begin
      drive = (state_d == S_ACTIVE) && (p_next >= PW'(BLANK_CYCLES));
      sel   = '0;
      col   = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (row_d == RW'(r)) begin
            sel[r] = drive;
            col    = drive ? snap_d[r*DATAWIDTH +: DATAWIDTH] : '0;
         end
      end
      rowo_d = sel ^ ROW_OFF;
      colo_d = col ^ COL_OFF;
   end

   always_ff @(posedge SC_Reg_MATRIX_CLOCK_50 or posedge SC_Reg_MATRIX_RESET_InHigh) begin
      if (SC_Reg_MATRIX_RESET_InHigh) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         snap_q  <= '0;
         fd_q    <= 1'b0;
         rowo_q  <= ROW_OFF;
         colo_q  <= COL_OFF;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         snap_q  <= snap_d;
         fd_q    <= fd_d;
         rowo_q  <= rowo_d;
         colo_q  <= colo_d;
      end
   end

   assign row_OutBUS         = rowo_q;
   assign col_OutBUS         = colo_q;
   assign row_index_Out      = row_q;
   assign frame_done_OutHigh = fd_q;

endmodule
